// File: rtl/riscv_mem_port_arbiter.sv
// Arbitrates one single-ported memory between fetch (IF) and memory-stage (D) ports.
// Ports: clk, rst (sync, active-low); IF req/addr/rdata/ack/stall; D req/we/addr/wdata/rdata/ack/stall;
//        memory side mem_en/mem_we/mem_addr/mem_wdata out, mem_rdata/mem_done in.
module riscv_mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    output logic              if_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              d_stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_done
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_IF,
        BUSY_D
    } state_t;

    state_t            state, stateNext;
    logic [CNT_W-1:0]  starveCnt, starveNext;
    logic              enNext, weNext;
    logic [ADDR_W-1:0] addrNext;
    logic [DATA_W-1:0] wdataNext;
    logic              ifAckNext, dAckNext;
    logic [DATA_W-1:0] ifRdataNext, dRdataNext;
    logic              ifLive, dLive, starved;

    // A port acked this cycle still shows its old req; ignore it.
    assign ifLive  = if_req & ~if_ack;
    assign dLive   = d_req & ~d_ack;
    assign starved = (starveCnt == CNT_W'(STARVE_MAX));

    // Stalls are forced low while reset is held so every output reads 0.
    assign if_stall = rst & if_req & ~if_ack;
    assign d_stall  = rst & d_req & ~d_ack;

    always_comb begin
        stateNext   = state;
        starveNext  = starveCnt;
        enNext      = 1'b0;
        weNext      = mem_we;
        addrNext    = mem_addr;
        wdataNext   = mem_wdata;
        ifAckNext   = 1'b0;
        dAckNext    = 1'b0;
        ifRdataNext = if_rdata;
        dRdataNext  = d_rdata;
        unique case (state)
            IDLE: begin
                if (!if_req) begin
                    starveNext = '0;
                end
                if (dLive && !(ifLive && starved)) begin
                    stateNext = BUSY_D;
                    enNext    = 1'b1;
                    weNext    = d_we;
                    addrNext  = d_addr;
                    wdataNext = d_wdata;
                    // D only beats a live IF while below the limit,
                    // so this increment never overflows.
                    if (ifLive) begin
                        starveNext = starveCnt + 1'b1;
                    end
                end else if (ifLive) begin
                    stateNext  = BUSY_IF;
                    enNext     = 1'b1;
                    weNext     = 1'b0;
                    addrNext   = if_addr;
                    starveNext = '0;
                end
            end
            BUSY_IF: begin
                // mem_en high marks the issue cycle; done is not yet valid.
                if (!mem_en && mem_done) begin
                    stateNext   = IDLE;
                    ifAckNext   = 1'b1;
                    ifRdataNext = mem_rdata;
                end
            end
            BUSY_D: begin
                if (!mem_en && mem_done) begin
                    stateNext = IDLE;
                    dAckNext  = 1'b1;
                    if (!mem_we) begin
                        dRdataNext = mem_rdata;
                    end
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            starveCnt <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_ack    <= 1'b0;
            d_ack     <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            state     <= stateNext;
            starveCnt <= starveNext;
            mem_en    <= enNext;
            mem_we    <= weNext;
            mem_addr  <= addrNext;
            mem_wdata <= wdataNext;
            if_ack    <= ifAckNext;
            d_ack     <= dAckNext;
            if_rdata  <= ifRdataNext;
            d_rdata   <= dRdataNext;
        end
    end

endmodule
